// File: rtl/umem_pkg.sv
// Shared types for the user-memory AXI4-Lite responder: response codes and FSM state encodings.
package umem_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_NEED_W,
    W_NEED_AW,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  localparam int unsigned LANE_W = 8;

endpackage

// File: rtl/umem_ram.sv
// Word RAM with one byte-enabled synchronous write port and one asynchronous read port.
module umem_ram
  import umem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DATA_W/LANE_W-1:0] wbe,
  input  logic [IDX_W-1:0]         waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [IDX_W-1:0]         raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / LANE_W; b++) begin
      if (we && wbe[b]) mem[waddr][LANE_W*b +: LANE_W] <= wdata[LANE_W*b +: LANE_W];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/umem_axil_responder.sv
// AXI4-Lite responder backed by a byte-enabled word RAM. Independent write (AW+W -> B)
// and read (AR -> R) FSMs, one outstanding transaction on each path.
module umem_axil_responder
  import umem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       RD_LAT      = 1
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/LANE_W-1:0] wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready
);

  localparam int unsigned     STRB_W    = DATA_W / LANE_W;
  localparam int unsigned     IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] SPAN      = (ADDR_W + 1)'(DEPTH_WORDS * 4);
  localparam logic [2:0]      WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [STRB_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (be[b]) m[LANE_W*b +: LANE_W] = new_w[LANE_W*b +: LANE_W];
    end
    return m;
  endfunction

  wr_state_t         wr_state, wr_next;
  rd_state_t         rd_state, rd_next;
  logic [2:0]        rd_cnt;
  logic [ADDR_W-1:0] awaddr_p0, araddr_p0, rd_addr;
  logic [DATA_W-1:0] wdata_p0, ram_rdata, rd_word;
  logic [STRB_W-1:0] wstrb_p0;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              aw_hs, w_hs, ar_hs, wr_ok, rd_ok, ram_we, rd_entry;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // ---- Write path: capture AW/W, commit, respond ----
  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_next = W_COMMIT;
        else if (aw_hs)    wr_next = W_NEED_W;
        else if (w_hs)     wr_next = W_NEED_AW;
      end
      W_NEED_W:  if (w_hs)  wr_next = W_COMMIT;
      W_NEED_AW: if (aw_hs) wr_next = W_COMMIT;
      W_COMMIT:  wr_next = W_RESP;
      W_RESP:    if (bvalid && bready) wr_next = W_IDLE;
      default:   wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_p0 <= awaddr;
    if (w_hs) begin
      wdata_p0 <= wdata;
      wstrb_p0 <= wstrb;
    end
  end

  assign wr_idx = word_idx(awaddr_p0);
  assign wr_ok  = addr_in_range(awaddr_p0);
  // Gated by the async-reset state, so asserting nreset mid-commit blocks the write at once.
  assign ram_we = (wr_state == W_COMMIT) && wr_ok;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
    end else begin
      wr_state <= wr_next;
      awready  <= (wr_next == W_IDLE) || (wr_next == W_NEED_AW);
      wready   <= (wr_next == W_IDLE) || (wr_next == W_NEED_W);
      bvalid   <= (wr_next == W_RESP);
      if (wr_state == W_COMMIT) bresp <= wr_ok ? OKAY : SLVERR;
    end
  end

  // ---- Read path: accept AR, wait RD_LAT-1 cycles, present R ----
  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = (RD_LAT <= 1) ? R_RESP : R_WAIT;
      R_WAIT:  if (rd_cnt == 3'd0) rd_next = R_RESP;
      R_RESP:  if (rvalid && rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ar_hs) araddr_p0 <= araddr;
  end

  // With RD_LAT=1 the RAM is read on the AR handshake edge itself, before araddr_p0 is loaded.
  assign rd_addr  = (rd_state == R_IDLE) ? araddr : araddr_p0;
  assign rd_idx   = word_idx(rd_addr);
  assign rd_ok    = addr_in_range(rd_addr);
  assign rd_entry = (rd_next == R_RESP) && (rd_state != R_RESP);

  umem_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .wbe   (wstrb_p0),
    .waddr (wr_idx),
    .wdata (wdata_p0),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  // A commit landing on the same edge as the read sample is forwarded (write-before-read).
  assign rd_word = (ram_we && (wr_idx == rd_idx)) ? merge_lanes(ram_rdata, wdata_p0, wstrb_p0)
                                                  : ram_rdata;

  // ---- Read response registers ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 3'd0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rresp    <= OKAY;
      rdata    <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs)                                   rd_cnt <= WAIT_INIT;
      else if (rd_state == R_WAIT && rd_cnt != 3'd0) rd_cnt <= rd_cnt - 3'd1;
      arready <= (rd_next == R_IDLE);
      rvalid  <= (rd_next == R_RESP);
      if (rd_entry) begin
        rdata <= rd_ok ? rd_word : '0;
        rresp <= rd_ok ? OKAY : SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_umem_axil_responder.sv
// Scoreboard bench for umem_axil_responder: instance A (RD_LAT=1) and instance B (RD_LAT=3).
`timescale 1ns/1ps
module tb_umem_axil_responder;

  localparam logic [1:0] R_OK  = 2'b00;
  localparam logic [1:0] R_ERR = 2'b10;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;

  logic [31:0] b_awaddr = '0, b_wdata = '0, b_araddr = '0, b_rdata;
  logic [3:0]  b_wstrb = '0;
  logic        b_awvalid = 0, b_wvalid = 0, b_bready = 0, b_arvalid = 0, b_rready = 0;
  logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]  b_bresp, b_rresp;

  umem_axil_responder #(.RD_LAT(1)) dut_a (
    .clk(clk), .nreset(nreset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  umem_axil_responder #(.RD_LAT(3)) dut_b (
    .clk(clk), .nreset(nreset),
    .awaddr(b_awaddr), .awvalid(b_awvalid), .awready(b_awready),
    .wdata(b_wdata), .wstrb(b_wstrb), .wvalid(b_wvalid), .wready(b_wready),
    .bresp(b_bresp), .bvalid(b_bvalid), .bready(b_bready),
    .araddr(b_araddr), .arvalid(b_arvalid), .arready(b_arready),
    .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(b_rready)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        rd_q[$];
  logic [1:0]  wr_q[$];
  logic [31:0] model [int];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit tb_in_range(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  // Expected results are queued at the moment stimulus is issued.
  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (tb_in_range(a)) begin
      model[idx] = tb_merge(model.exists(idx) ? model[idx] : 32'h0, d, s);
      wr_q.push_back(R_OK);
    end else begin
      wr_q.push_back(R_ERR);
    end
  endtask

  task automatic push_read(input logic [31:0] a);
    exp_t e;
    if (tb_in_range(a)) begin
      e.data = model[int'(a >> 2)];
      e.resp = R_OK;
    end else begin
      e.data = 32'h0;
      e.resp = R_ERR;
    end
    rd_q.push_back(e);
  endtask

  task automatic send_aw(input logic [31:0] a, output bit to);
    awaddr = a; awvalid = 1; to = 1;
    for (int i = 0; i < 20; i++) begin
      if (awready) begin @(negedge clk); to = 0; break; end
      @(negedge clk);
    end
    awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output bit to);
    wdata = d; wstrb = s; wvalid = 1; to = 1;
    for (int i = 0; i < 20; i++) begin
      if (wready) begin @(negedge clk); to = 0; break; end
      @(negedge clk);
    end
    wvalid = 0;
  endtask

  task automatic send_ar(input logic [31:0] a, output bit to);
    araddr = a; arvalid = 1; to = 1;
    for (int i = 0; i < 20; i++) begin
      if (arready) begin @(negedge clk); to = 0; break; end
      @(negedge clk);
    end
    arvalid = 0;
  endtask

  task automatic wait_b(output logic [1:0] r, output bit to);
    bready = 1; to = 1; r = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin r = bresp; @(negedge clk); to = 0; break; end
      @(negedge clk);
    end
    bready = 0;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r, output bit to);
    rready = 1; to = 1; d = 'x; r = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin d = rdata; r = rresp; @(negedge clk); to = 0; break; end
      @(negedge clk);
    end
    rready = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] got, output bit to);
    bit t1, t2, t3;
    push_write(a, d, s);
    send_aw(a, t1);
    send_w(d, s, t2);
    wait_b(got, t3);
    to = t1 | t2 | t3;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output bit to);
    bit t1, t2;
    push_read(a);
    send_ar(a, t1);
    wait_r(d, r, t2);
    to = t1 | t2;
  endtask

  task automatic test_reset;
    bit to;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_hs got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_cmp++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      n_fail++; $display("FAIL reset_data got=%h want=0", {bresp, rresp, rdata});
    end
    nreset = 1;
    #1;
    n_cmp++;
    if ({arready, b_arready} !== 2'b00) begin
      n_fail++; $display("FAIL ready_before_edge got=%b want=00", {arready, b_arready});
    end
    @(negedge clk);
    n_cmp++;
    if ({awready, wready, arready, b_arready} !== 4'b1111) begin
      n_fail++; $display("FAIL ready_after_edge got=%b want=1111", {awready, wready, arready, b_arready});
    end
    send_ar(32'h0, to);
    n_cmp++;
    if ({to, rvalid} !== 2'b01) begin
      n_fail++; $display("FAIL midread_rvalid got=%b want=01", {to, rvalid});
    end
    nreset = 0;
    #1;
    n_cmp++;
    if ({rvalid, arready} !== 2'b00) begin
      n_fail++; $display("FAIL async_reset got=%b want=00", {rvalid, arready});
    end
    @(negedge clk);
    nreset = 1;
    @(negedge clk);
    n_cmp++;
    if ({arready, rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL rerelease got=%b want=10", {arready, rvalid});
    end
  endtask

  task automatic test_aw_then_w;
    logic [31:0] d; logic [1:0] r, want; bit to; exp_t e;
    awaddr = 32'h10; awvalid = 1;
    push_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    awvalid = 0;
    @(negedge clk);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    n_cmp++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL bvalid_early got=%b want=0", bvalid); end
    @(negedge clk);
    want = wr_q.pop_front();
    n_cmp++;
    if ({bvalid, bresp} !== {1'b1, want}) begin
      n_fail++; $display("FAIL b_latency got=%b/%b want=1/%b", bvalid, bresp, want);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bvalid, awready, wready} !== 3'b100) begin
        n_fail++; $display("FAIL b_stall got=%b want=100", {bvalid, awready, wready});
      end
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    n_cmp++;
    if ({bvalid, awready} !== 2'b01) begin
      n_fail++; $display("FAIL b_release got=%b want=01", {bvalid, awready});
    end
    do_read(32'h10, d, r, to);
    e = rd_q.pop_front();
    n_cmp++;
    if ({to, r, d} !== {1'b0, e.resp, e.data}) begin
      n_fail++; $display("FAIL read_0x10 got=%h/%b want=%h/%b to=%b", d, r, e.data, e.resp, to);
    end
  endtask

  task automatic test_w_before_aw;
    logic [31:0] d; logic [1:0] r, want; bit t1, t2, t3; exp_t e;
    push_write(32'h10, 32'h0000_AB00, 4'b0010);
    send_w(32'h0000_AB00, 4'b0010, t1);
    n_cmp++;
    if ({t1, awready, wready} !== 3'b010) begin
      n_fail++; $display("FAIL need_aw_ready got=%b want=010", {t1, awready, wready});
    end
    send_aw(32'h10, t2);
    wait_b(r, t3);
    want = wr_q.pop_front();
    n_cmp++;
    if ({t2, t3, r} !== {2'b00, want}) begin
      n_fail++; $display("FAIL w_first_bresp got=%b want=%b", {t2, t3, r}, {2'b00, want});
    end
    do_read(32'h10, d, r, t1);
    e = rd_q.pop_front();
    n_cmp++;
    if ({t1, r, d} !== {1'b0, e.resp, e.data} || d !== 32'hDEAD_ABEF) begin
      n_fail++; $display("FAIL strb_merge got=%h/%b want=%h/%b", d, r, e.data, e.resp);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] addrs [6];
    logic [31:0] d; logic [1:0] r, want; bit to; exp_t e;
    do_write(32'h0, 32'h1111_1111, 4'hF, r, to);
    want = wr_q.pop_front();
    n_cmp++;
    if ({to, r} !== {1'b0, want}) begin n_fail++; $display("FAIL wr0 got=%b want=%b", r, want); end
    do_write(32'h1000, 32'hFFFF_FFFF, 4'hF, r, to);
    want = wr_q.pop_front();
    n_cmp++;
    if ({to, r} !== {1'b0, want}) begin n_fail++; $display("FAIL wr_oor got=%b want=%b", r, want); end
    do_write(32'hFFC, 32'hA5C3_5A3C, 4'hF, r, to);
    want = wr_q.pop_front();
    n_cmp++;
    if ({to, r} !== {1'b0, want}) begin n_fail++; $display("FAIL wr_top got=%b want=%b", r, want); end
    addrs = '{32'h1000, 32'h0, 32'hFFF, 32'hFFFF_FFFC, 32'h1003, 32'h2};
    foreach (addrs[i]) begin
      do_read(addrs[i], d, r, to);
      e = rd_q.pop_front();
      n_cmp++;
      if ({to, r, d} !== {1'b0, e.resp, e.data}) begin
        n_fail++; $display("FAIL range_rd[%h] got=%h/%b want=%h/%b", addrs[i], d, r, e.data, e.resp);
      end
    end
  endtask

  task automatic test_rd_lat3;
    logic [31:0] want_d;
    int k;
    b_awaddr = 32'h40; b_wdata = 32'h1234_5678; b_wstrb = 4'hF;
    b_awvalid = 1; b_wvalid = 1;
    @(negedge clk);
    b_awvalid = 0; b_wvalid = 0; b_bready = 1;
    k = 0;
    while (!b_bvalid && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if ({b_bvalid, b_bresp} !== {1'b1, R_OK}) begin
      n_fail++; $display("FAIL b_write got=%b/%b want=1/%b", b_bvalid, b_bresp, R_OK);
    end
    @(negedge clk);
    b_bready = 0;
    want_d = 32'h1234_5678;
    b_araddr = 32'h40; b_arvalid = 1;
    @(negedge clk);
    b_arvalid = 0;
    for (int c = 1; c <= 2; c++) begin
      n_cmp++;
      if ({b_rvalid, b_arready} !== 2'b00) begin
        n_fail++; $display("FAIL lat3_wait[%0d] got=%b want=00", c, {b_rvalid, b_arready});
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({b_rvalid, b_rresp, b_rdata} !== {1'b1, R_OK, want_d}) begin
      n_fail++; $display("FAIL lat3_rvalid got=%b/%b/%h want=1/%b/%h", b_rvalid, b_rresp, b_rdata, R_OK, want_d);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({b_rvalid, b_arready, b_rdata} !== {2'b10, want_d}) begin
        n_fail++; $display("FAIL lat3_stall[%0d] got=%b/%h want=10/%h", c, {b_rvalid, b_arready}, b_rdata, want_d);
      end
    end
    b_rready = 1;
    @(negedge clk);
    b_rready = 0;
    n_cmp++;
    if ({b_rvalid, b_arready} !== 2'b01) begin
      n_fail++; $display("FAIL lat3_release got=%b want=01", {b_rvalid, b_arready});
    end
  endtask

  task automatic test_collision;
    logic [31:0] cd [2];
    logic [3:0]  cs [2];
    logic [1:0] r, want; bit to; exp_t e;
    cd = '{32'hCAFE_F00D, 32'h7700_0000};
    cs = '{4'hF, 4'b1000};
    do_write(32'h20, 32'h0101_0101, 4'hF, r, to);
    want = wr_q.pop_front();
    n_cmp++;
    if ({to, r} !== {1'b0, want}) begin n_fail++; $display("FAIL col_pre got=%b want=%b", r, want); end
    for (int i = 0; i < 2; i++) begin
      awaddr = 32'h20; wdata = cd[i]; wstrb = cs[i]; awvalid = 1; wvalid = 1;
      push_write(32'h20, cd[i], cs[i]);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      araddr = 32'h20; arvalid = 1;
      push_read(32'h20);
      @(negedge clk);
      arvalid = 0;
      e = rd_q.pop_front();
      want = wr_q.pop_front();
      n_cmp++;
      if ({rvalid, rresp, rdata} !== {1'b1, e.resp, e.data}) begin
        n_fail++; $display("FAIL collision[%0d] got=%b/%b/%h want=1/%b/%h", i, rvalid, rresp, rdata, e.resp, e.data);
      end
      n_cmp++;
      if ({bvalid, bresp} !== {1'b1, want}) begin
        n_fail++; $display("FAIL col_b[%0d] got=%b/%b want=1/%b", i, bvalid, bresp, want);
      end
      rready = 1; bready = 1;
      @(negedge clk);
      rready = 0; bready = 0;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic [1:0] r, want; bit to; exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 6; i++) begin
        do_write(32'h100 + 32'(i) * 32'h44, $urandom,
                 (pass == 0) ? 4'hF : 4'($urandom_range(0, 15)), r, to);
        want = wr_q.pop_front();
        n_cmp++;
        if ({to, r} !== {1'b0, want}) begin
          n_fail++; $display("FAIL b2b_wr[%0d.%0d] got=%b want=%b", pass, i, r, want);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      do_read(32'h100 + 32'(i) * 32'h44, d, r, to);
      e = rd_q.pop_front();
      n_cmp++;
      if ({to, r, d} !== {1'b0, e.resp, e.data}) begin
        n_fail++; $display("FAIL b2b_rd[%0d] got=%h/%b want=%h/%b", i, d, r, e.data, e.resp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aw_then_w();
    test_w_before_aw();
    test_out_of_range();
    test_rd_lat3();
    test_collision();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1);
  end

endmodule
